// File: rtl/desc_pair_pkg.sv
// desc_pair_pkg: shared state type and sizing constants for desc_pair_merger
package desc_pair_pkg;
  localparam int DESC_WIDTH_DEF = 64;
  localparam int TIMER_W = 8;
  typedef enum logic {IDLE, HOLD} state_e;
endpackage

// File: rtl/desc_pair_out_reg.sv
// desc_pair_out_reg: merged-entry output register O with valid/ready holding
module desc_pair_out_reg
  import desc_pair_pkg::*;
#(
  parameter int DESC_WIDTH = DESC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic [DESC_WIDTH-1:0] ld_desc,
  input  logic [DESC_WIDTH-1:0] ld_ext,
  input  logic                  ld_has_ext,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DESC_WIDTH-1:0] m_desc,
  output logic [DESC_WIDTH-1:0] m_desc_ext,
  output logic                  m_desc_has_ext
);
  logic                  valid_q, valid_d;
  logic [DESC_WIDTH-1:0] desc_q, desc_d, ext_q, ext_d;
  logic                  has_ext_q, has_ext_d;
  always_comb begin
    valid_d   = flush ? 1'b0 : load ? 1'b1 : valid_q && !m_ready;
    desc_d    = flush ? '0 : load ? ld_desc : desc_q;
    ext_d     = flush ? '0 : load ? ld_ext : ext_q;
    has_ext_d = flush ? 1'b0 : load ? ld_has_ext : has_ext_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      desc_q    <= '0;
      ext_q     <= '0;
      has_ext_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      desc_q    <= desc_d;
      ext_q     <= ext_d;
      has_ext_q <= has_ext_d;
    end
  end
  assign m_valid        = valid_q;
  assign m_desc         = desc_q;
  assign m_desc_ext     = ext_q;
  assign m_desc_has_ext = has_ext_q;
endmodule

// File: rtl/desc_pair_merger.sv
// desc_pair_merger: pairs a first descriptor beat with an optional second beat, with hold timeout.
// Define DESC_PAIR_STATS_EN to build the pair/single/orphan event counters.
module desc_pair_merger
  import desc_pair_pkg::*;
#(
  parameter int DESC_WIDTH   = DESC_WIDTH_DEF,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DESC_WIDTH-1:0] s_desc,
  input  logic                  s_desc_2nd,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  output logic [DESC_WIDTH-1:0] m_desc,
  output logic [DESC_WIDTH-1:0] m_desc_ext,
  output logic                  m_desc_has_ext,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_orphan,
  output logic [31:0]           stat_pair,
  output logic [31:0]           stat_single,
  output logic [31:0]           stat_orphan
);
  state_e               state_q, state_d;
  logic [DESC_WIDTH-1:0] h_q, h_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 err_orphan_q, err_orphan_d;
  logic                 o_free, accept, o_load, o_has_ext;
  logic [DESC_WIDTH-1:0] o_ext;
  assign o_free       = !m_valid || m_ready;
  assign s_desc_ready = rst_n && o_free && !flush;
  assign accept       = s_desc_valid && s_desc_ready;
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    timer_d      = timer_q;
    o_load       = 1'b0;
    o_ext        = '0;
    o_has_ext    = 1'b0;
    err_orphan_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      h_d     = '0;
      timer_d = '0;
    end else if (state_q == IDLE) begin
      if (accept && s_desc_2nd) err_orphan_d = 1'b1;
      else if (accept) begin
        h_d     = s_desc;
        timer_d = '0;
        state_d = HOLD;
      end
    end else if (accept) begin
      // an arriving beat always wins over a coincident timeout so pairing is never missed
      o_load    = 1'b1;
      o_ext     = s_desc_2nd ? s_desc : '0;
      o_has_ext = s_desc_2nd;
      h_d       = s_desc_2nd ? '0 : s_desc;
      timer_d   = '0;
      state_d   = s_desc_2nd ? IDLE : HOLD;
    end else if (timer_q != TIMER_W'(HOLD_TIMEOUT)) timer_d = timer_q + 1'b1;
    else if (o_free) begin
      o_load  = 1'b1;
      h_d     = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      h_q          <= '0;
      timer_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      timer_q      <= timer_d;
      err_orphan_q <= err_orphan_d;
    end
  end
  assign err_orphan = err_orphan_q;
  desc_pair_out_reg #(.DESC_WIDTH(DESC_WIDTH)) u_out (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .load          (o_load),
    .ld_desc       (h_q),
    .ld_ext        (o_ext),
    .ld_has_ext    (o_has_ext),
    .m_ready       (m_ready),
    .m_valid       (m_valid),
    .m_desc        (m_desc),
    .m_desc_ext    (m_desc_ext),
    .m_desc_has_ext(m_desc_has_ext)
  );
`ifdef DESC_PAIR_STATS_EN
  logic [31:0] stat_pair_q, stat_pair_d, stat_single_q, stat_single_d, stat_orphan_q, stat_orphan_d;
  always_comb begin
    stat_pair_d   = stat_pair_q + 32'(o_load && o_has_ext);
    stat_single_d = stat_single_q + 32'(o_load && !o_has_ext);
    stat_orphan_d = stat_orphan_q + 32'(err_orphan_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pair_q   <= '0;
      stat_single_q <= '0;
      stat_orphan_q <= '0;
    end else begin
      stat_pair_q   <= stat_pair_d;
      stat_single_q <= stat_single_d;
      stat_orphan_q <= stat_orphan_d;
    end
  end
  assign stat_pair   = stat_pair_q;
  assign stat_single = stat_single_q;
  assign stat_orphan = stat_orphan_q;
`else
  assign stat_pair   = '0;
  assign stat_single = '0;
  assign stat_orphan = '0;
`endif
endmodule

// File: tb/tb_desc_pair_merger.sv
// tb_desc_pair_merger: directed table, corner sequences and random traffic against a beat-level model
module tb_desc_pair_merger;
  localparam int TO = 16;
  logic        clk, rst_n, flush, s_desc_2nd, s_desc_valid, s_desc_ready;
  logic [63:0] s_desc, m_desc, m_desc_ext;
  logic        m_desc_has_ext, m_valid, m_ready, err_orphan;
  logic [31:0] stat_pair, stat_single, stat_orphan;
  int nvec = 0, nerr = 0;
  desc_pair_merger #(.DESC_WIDTH(64), .HOLD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_desc(s_desc), .s_desc_2nd(s_desc_2nd),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready), .m_desc(m_desc),
    .m_desc_ext(m_desc_ext), .m_desc_has_ext(m_desc_has_ext), .m_valid(m_valid),
    .m_ready(m_ready), .err_orphan(err_orphan), .stat_pair(stat_pair),
    .stat_single(stat_single), .stat_orphan(stat_orphan)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  bit          mh_v, mo_v, mo_h, merr;
  logic [63:0] mh, mo_d, mo_e;
  int          mage;
  int unsigned mpair, msingle, morph;
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic void model_reset();
    mh_v = 0; mo_v = 0; mo_h = 0; merr = 0; mh = 0; mo_d = 0; mo_e = 0; mage = 0;
    mpair = 0; msingle = 0; morph = 0;
  endfunction
  function automatic void push(logic [63:0] d, logic [63:0] e, bit h);
    mo_v = 1; mo_d = d; mo_e = e; mo_h = h;
  endfunction
  function automatic void model_step();
    bit ofree, acc;
    ofree = !mo_v || m_ready;
    acc = s_desc_valid && ofree && !flush;
    merr = 0;
    if (mo_v && m_ready) mo_v = 0;
    if (flush) begin
      mh_v = 0; mage = 0; mo_v = 0; mo_d = 0; mo_e = 0; mo_h = 0;
    end else if (acc && s_desc_2nd) begin
      if (!mh_v) begin merr = 1; morph++; end
      else begin push(mh, s_desc, 1); mpair++; mh_v = 0; end
    end else if (acc) begin
      if (mh_v) begin push(mh, 0, 0); msingle++; end
      mh = s_desc; mh_v = 1; mage = 0;
    end else if (mh_v) begin
      if (mage < TO) mage++;
      else if (ofree) begin push(mh, 0, 0); msingle++; mh_v = 0; end
    end
  endfunction
  task automatic check_model();
    chk("m_valid", m_valid, mo_v);
    if (mo_v) begin
      chk("m_desc", m_desc, mo_d);
      chk("m_desc_ext", m_desc_ext, mo_e);
      chk("m_desc_has_ext", m_desc_has_ext, mo_h);
    end
    chk("err_orphan", err_orphan, merr);
`ifdef DESC_PAIR_STATS_EN
    chk("stat_pair", stat_pair, mpair);
    chk("stat_single", stat_single, msingle);
    chk("stat_orphan", stat_orphan, morph);
`else
    chk("stat_pair", stat_pair, 0);
    chk("stat_single", stat_single, 0);
    chk("stat_orphan", stat_orphan, 0);
`endif
  endtask
  task automatic tick();
    #1;
    chk("s_desc_ready", s_desc_ready, (!mo_v || m_ready) && !flush);
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask
  task automatic drive(bit fl, bit v, bit s2, logic [63:0] b, bit mr);
    flush = fl; s_desc_valid = v; s_desc_2nd = s2; s_desc = b; m_ready = mr;
  endtask
  typedef struct {
    bit fl, v, s2; logic [63:0] beat; bit mr, ev; logic [63:0] ed, ee; bit eh, eerr;
  } vec_t;
  vec_t tbl[10];
  initial begin
    int n;
    bit sparse;
    tbl[0] = '{0, 0, 0, 64'h0, 1, 0, 64'h0, 64'h0, 0, 0};
    tbl[1] = '{0, 1, 0, 64'hA, 1, 0, 64'h0, 64'h0, 0, 0};
    tbl[2] = '{0, 1, 1, 64'hB, 1, 1, 64'hA, 64'hB, 1, 0};
    tbl[3] = '{0, 0, 0, 64'h0, 1, 0, 64'h0, 64'h0, 0, 0};
    tbl[4] = '{0, 1, 0, 64'h1, 1, 0, 64'h0, 64'h0, 0, 0};
    tbl[5] = '{0, 1, 0, 64'h2, 1, 1, 64'h1, 64'h0, 0, 0};
    tbl[6] = '{0, 1, 1, 64'h3, 1, 1, 64'h2, 64'h3, 1, 0};
    tbl[7] = '{0, 0, 0, 64'h0, 1, 0, 64'h0, 64'h0, 0, 0};
    tbl[8] = '{0, 1, 1, 64'hD, 1, 0, 64'h0, 64'h0, 0, 1};
    tbl[9] = '{0, 0, 0, 64'h0, 1, 0, 64'h0, 64'h0, 0, 0};
    rst_n = 0;
    drive(0, 0, 0, 0, 1);
    model_reset();
    #1;
    chk("rst_ready", s_desc_ready, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_has_ext", m_desc_has_ext, 0);
    chk("rst_err", err_orphan, 0);
    chk("rst_stat_pair", stat_pair, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].fl, tbl[i].v, tbl[i].s2, tbl[i].beat, tbl[i].mr);
      tick();
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_desc", i), m_desc, tbl[i].ed);
        chk($sformatf("tbl%0d_ext", i), m_desc_ext, tbl[i].ee);
        chk($sformatf("tbl%0d_has_ext", i), m_desc_has_ext, tbl[i].eh);
      end
      chk($sformatf("tbl%0d_err", i), err_orphan, tbl[i].eerr);
    end
`ifdef DESC_PAIR_STATS_EN
    chk("tbl_stat_pair", stat_pair, 2);
    chk("tbl_stat_single", stat_single, 1);
    chk("tbl_stat_orphan", stat_orphan, 1);
`endif
    drive(0, 1, 0, 64'hC, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    n = 1;
    while (n <= 40) begin
      tick();
      if (m_valid) break;
      n++;
    end
    chk("timeout_latency", n, TO + 1);
    chk("timeout_desc", m_desc, 64'hC);
    chk("timeout_ext", m_desc_ext, 0);
    chk("timeout_has_ext", m_desc_has_ext, 0);
    tick();
    drive(0, 1, 0, 64'h55, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    #1 rst_n = 0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_ready", s_desc_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    drive(0, 1, 1, 64'h56, 1);
    tick();
    chk("midrst_orphan", err_orphan, 1);
    drive(0, 0, 0, 0, 1);
    tick();
    chk("orphan_pulse_end", err_orphan, 0);
    drive(0, 1, 0, 64'hE, 0);
    tick();
    drive(0, 1, 0, 64'h21, 0);
    tick();
    drive(0, 1, 1, 64'h22, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("bp_ready", s_desc_ready, 0);
      chk("bp_desc", m_desc, 64'hE);
    end
    m_ready = 1;
    tick();
    chk("bp_pair_valid", m_valid, 1);
    chk("bp_pair_desc", m_desc, 64'h21);
    chk("bp_pair_ext", m_desc_ext, 64'h22);
    chk("bp_pair_has_ext", m_desc_has_ext, 1);
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 1, 0, 64'h30, 0);
    tick();
    drive(0, 1, 0, 64'hF, 0);
    tick();
    chk("fl_pre_valid", m_valid, 1);
    drive(1, 0, 0, 0, 0);
    tick();
    chk("fl_valid", m_valid, 0);
    drive(0, 1, 1, 64'h31, 1);
    tick();
    chk("fl_orphan", err_orphan, 1);
    chk("fl_no_out", m_valid, 0);
    sparse = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) sparse = $urandom_range(1);
      drive($urandom_range(63) == 0,
            sparse ? $urandom_range(19) == 0 : $urandom_range(1) == 1,
            $urandom_range(9) < 4, {$urandom, $urandom},
            sparse ? $urandom_range(3) == 0 : $urandom_range(9) < 7);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/desc_pair_merger.md
DESC_PAIR_MERGER -- requirements
Module: desc_pair_merger

Interface
REQ-001 Parameter DESC_WIDTH, default 64, SHALL set the width of one descriptor beat.
REQ-002 Parameter HOLD_TIMEOUT, default 16, legal 1..255, SHALL set the idle cycles a first beat waits for its second beat.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port flush, input, 1 bit, SHALL be a synchronous core-reset flush.
REQ-006 Port s_desc, input, DESC_WIDTH bits, SHALL carry the core's outgoing descriptor beat.
REQ-007 Port s_desc_2nd, input, 1 bit, SHALL mark the beat as the second half of the previous beat.
REQ-008 Ports s_desc_valid (input, 1 bit) and s_desc_ready (output, 1 bit) SHALL form the input handshake.
REQ-009 Port m_desc, output, DESC_WIDTH bits, SHALL carry the first beat.
REQ-010 Port m_desc_ext, output, DESC_WIDTH bits, SHALL carry the second beat, or zero when absent.
REQ-011 Port m_desc_has_ext, output, 1 bit, SHALL flag that m_desc_ext is valid.
REQ-012 Ports m_valid (output, 1 bit) and m_ready (input, 1 bit) SHALL form the output handshake.
REQ-013 Port err_orphan, output, 1 bit, SHALL pulse for one cycle when an orphan second beat is dropped.
REQ-014 Ports stat_pair, stat_single and stat_orphan, outputs, 32 bits each, SHALL be event counters.

Function
REQ-015 The block SHALL hold one beat in register H and one merged entry in output register O.
REQ-016 The FSM SHALL have two states, IDLE (H empty) and HOLD (H full).
REQ-017 s_desc_ready SHALL equal (!m_valid || m_ready) && !flush in both states.
REQ-018 An accepted beat SHALL be a cycle with s_desc_valid && s_desc_ready.
REQ-019 IDLE, accepted beat with 2nd=0: load H, clear timer, go to HOLD.
REQ-020 IDLE, accepted beat with 2nd=1: drop the beat, pulse err_orphan, stay IDLE.
REQ-021 HOLD, accepted beat with 2nd=1: load O with {H, beat, has_ext=1}, go to IDLE.
REQ-022 HOLD, accepted beat with 2nd=0: load O with {H, 0, has_ext=0}, load H with the beat, clear timer, stay HOLD.
REQ-023 HOLD, no accepted beat: increment timer, saturating at HOLD_TIMEOUT.
REQ-024 Timeout: when timer==HOLD_TIMEOUT and O is free (!m_valid || m_ready), load O with {H, 0, 0} and go to IDLE.
REQ-025 Timeout with O full SHALL keep H until O frees, with no loss.
REQ-026 A beat accepted in the same cycle as a timeout SHALL take priority, so pairing still occurs.
REQ-027 Latency from accepting the completing beat to m_valid high SHALL be exactly 1 cycle.
REQ-028 m_valid SHALL stay high, and O stable, until m_ready is sampled high.
REQ-029 O SHALL reload in the same cycle as it drains when a new entry is ready, giving full throughput.
REQ-030 flush SHALL, on the next edge, clear H, the timer and O, force IDLE, and leave the counters unchanged.

Reset
REQ-031 With rst_n low, state SHALL be IDLE and H, O, m_valid, m_desc_has_ext, err_orphan and all counters SHALL be 0.
REQ-032 With rst_n low, s_desc_ready SHALL read 0.
REQ-033 Reset assertion mid-pair SHALL discard the held beat.

Configuration
REQ-034 Macro DESC_PAIR_STATS_EN defined: stat_pair, stat_single and stat_orphan SHALL increment, wrapping, on each REQ-021, REQ-022/024 and REQ-020 event respectively.
REQ-035 Macro DESC_PAIR_STATS_EN absent: the stat outputs SHALL be tied to 0 and no counter flops SHALL exist; err_orphan SHALL remain in both builds.

Structure
REQ-036 Package desc_pair_pkg SHALL hold the state enum (IDLE, HOLD), the DESC_WIDTH default and the timer width constant (8).
REQ-037 One sub-module, desc_pair_out_reg, SHALL implement O with its valid/ready logic; the FSM and counters SHALL stay in the top.

Verification
REQ-038 Pair case: beat 0xA (2nd=0) then 0xB (2nd=1) back-to-back, m_ready=1 -> one output {0xA, 0xB, has_ext=1} one cycle after 0xB; stat_pair=1.
REQ-039 Timeout case: beat 0xC alone, HOLD_TIMEOUT=16 -> output {0xC, 0, 0} after 16 idle cycles plus 1; stat_single=1.
REQ-040 Single-single-pair case: beats 0x1, 0x2, 0x3 (2nd=1) -> outputs {0x1, -, 0}, then {0x2, 0x3, 1}.
REQ-041 Orphan case: 2nd=1 beat 0xD while IDLE -> no output, err_orphan high for 1 cycle, stat_orphan=1.
REQ-042 Backpressure case: m_ready=0 for 40 cycles with 0xE held -> s_desc_ready=0 after O fills, no loss; the first output appears when m_ready rises.
REQ-043 Flush case: flush while in HOLD with 0xF, O holding an entry -> m_valid=0 next cycle; a following 2nd=1 beat counts as an orphan.
